// File: rtl/generador_bit_flip_pkg.sv
// Shared definitions for the bus-invert decision stage: operating modes,
// default width and a generic population-count helper.
package pkg_flipping;

    localparam int N_DEFAULT    = 16;
    localparam int MODO_UNOS    = 0;
    localparam int MODO_HAMMING = 1;
    localparam int POP_MAX_W    = 64;

    // Callers zero-extend narrower words to POP_MAX_W before counting.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/generador_bit_flip_contador_unos.sv
// Combinational ones counter; the result is wide enough to hold N itself.
module contador_unos
    import pkg_flipping::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0]           dato,
    output logic [$clog2(N+1)-1:0] cuenta
);

    localparam int PW = $clog2(N+1);

    always_comb begin
        cuenta = PW'(popcount(POP_MAX_W'(dato)));
    end

endmodule

// File: rtl/generador_bit_flip.sv
// Bus-invert decision stage: two-stage valid/ready pipeline that tags each
// activation with the flip bit minimising bus toggles, plus a flip counter.
module generador_bit_flip
    import pkg_flipping::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int MODE = MODO_HAMMING,
    parameter int CW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_stats,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  input_activacion,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_activacion,
    output logic          out_f_bit,
    output logic [CW-1:0] num_flips
);

    localparam int PW = $clog2(N+1);

    logic [N-1:0]  s1_data_q, s1_data_d;
    logic          s1_valid_q, s1_valid_d;
    logic [N-1:0]  s2_data_q, s2_data_d;
    logic          s2_f_q, s2_f_d;
    logic          s2_valid_q, s2_valid_d;
    logic [N-1:0]  prev_bus_q, prev_bus_d;
    logic [CW-1:0] num_flips_q, num_flips_d;

    logic          s1_adv;
    logic [N-1:0]  operando;
    logic [PW-1:0] distancia;
    logic          f_dec;

    // Hamming mode compares against the encoded word last placed on the bus.
    always_comb begin
        operando = (MODE == MODO_HAMMING) ? (s1_data_q ^ prev_bus_q) : s1_data_q;
    end

    contador_unos #(.N(N)) u_contador_unos (
        .dato   (operando),
        .cuenta (distancia)
    );

    always_comb begin
        s1_adv   = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready = ~s1_valid_q | s1_adv;
        f_dec    = (distancia > PW'(N/2));
    end

    always_comb begin
        s1_data_d   = s1_data_q;
        s1_valid_d  = s1_valid_q;
        s2_data_d   = s2_data_q;
        s2_f_d      = s2_f_q;
        s2_valid_d  = s2_valid_q;
        prev_bus_d  = prev_bus_q;
        num_flips_d = num_flips_q;

        if (in_valid && in_ready) begin
            s1_data_d  = input_activacion;
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_data_d  = s1_data_q;
            s2_f_d     = f_dec;
            s2_valid_d = 1'b1;
            prev_bus_d = f_dec ? ~s1_data_q : s1_data_q;
        end else if (s2_valid_q && out_ready) begin
            s2_valid_d = 1'b0;
        end

        // Clear wins over a same-cycle increment.
        if (clr_stats) begin
            num_flips_d = '0;
        end else if (s1_adv && f_dec && (num_flips_q != '1)) begin
            num_flips_d = num_flips_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q   <= '0;
            s1_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_f_q      <= 1'b0;
            s2_valid_q  <= 1'b0;
            prev_bus_q  <= '0;
            num_flips_q <= '0;
        end else begin
            s1_data_q   <= s1_data_d;
            s1_valid_q  <= s1_valid_d;
            s2_data_q   <= s2_data_d;
            s2_f_q      <= s2_f_d;
            s2_valid_q  <= s2_valid_d;
            prev_bus_q  <= prev_bus_d;
            num_flips_q <= num_flips_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_activacion = s2_data_q;
    assign out_f_bit      = s2_f_q;
    assign num_flips      = num_flips_q;

endmodule

// File: tb/tb_generador_bit_flip.sv
// Scoreboard bench: a Hamming-mode instance with random traffic and a
// ones-count instance with a 4-bit saturating flip counter.
module tb_generador_bit_flip;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_stats = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] input_activacion = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_activacion;
    logic        out_f_bit;
    logic [15:0] num_flips;

    logic        clr_b = 1'b0;
    logic        in_valid_b = 1'b0;
    logic        in_ready_b;
    logic [15:0] in_data_b = '0;
    logic        out_valid_b;
    logic        out_ready_b = 1'b1;
    logic [15:0] out_data_b;
    logic        out_f_b;
    logic [3:0]  num_flips_b;

    always #5 clk = ~clk;

    generador_bit_flip #(.N(16), .MODE(1), .CW(16)) dut (
        .clk(clk), .rst(rst), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(in_ready), .input_activacion(input_activacion),
        .out_valid(out_valid), .out_ready(out_ready), .out_activacion(out_activacion),
        .out_f_bit(out_f_bit), .num_flips(num_flips)
    );

    generador_bit_flip #(.N(16), .MODE(0), .CW(4)) dut_b (
        .clk(clk), .rst(rst), .clr_stats(clr_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .input_activacion(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_activacion(out_data_b),
        .out_f_bit(out_f_b), .num_flips(num_flips_b)
    );

    typedef struct {
        logic [15:0] d;
        logic        f;
        int          cyc;
    } item_t;

    item_t       sb[$];
    item_t       sbb[$];
    logic [15:0] log_d[$];
    logic        log_f[$];
    logic        logb_f[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;
    logic [15:0] m_prev = '0;
    int          m_flips = 0;
    int          m_emit = 0;
    int          mb_flips = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference for the Hamming instance: bus word history and decision count.
    always @(negedge clk) begin
        item_t it;
        cyc++;
        if (rst) begin
            sb.delete();
            m_prev  = '0;
            m_flips = 0;
            m_emit  = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", out_activacion);
                end else begin
                    it = sb.pop_front();
                    chk("out_data", 32'(out_activacion), 32'(it.d));
                    chk("out_f", 32'(out_f_bit), 32'(it.f));
                    if (lat_chk) chk("latency", 32'(cyc - it.cyc), 32'd2);
                    m_emit += int'(it.f);
                    checks++;
                    if (int'(num_flips) < m_emit || int'(num_flips) > m_flips) begin
                        errors++;
                        $display("FAIL flips_range actual=%0d required=%0d..%0d", num_flips, m_emit, m_flips);
                    end
                    log_d.push_back(out_activacion);
                    log_f.push_back(out_f_bit);
                end
            end
            if (in_valid && in_ready) begin
                it.d   = input_activacion;
                it.f   = ($countones(input_activacion ^ m_prev) > 8);
                it.cyc = cyc;
                if (it.f) begin
                    m_prev = ~input_activacion;
                    m_flips++;
                end else begin
                    m_prev = input_activacion;
                end
                sb.push_back(it);
            end
        end
    end

    always @(negedge clk) begin
        item_t it;
        if (rst) begin
            sbb.delete();
            mb_flips = 0;
        end else begin
            if (clr_b) mb_flips = 0;
            if (out_valid_b && out_ready_b) begin
                if (sbb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output_b actual=%0h required=none", out_data_b);
                end else begin
                    it = sbb.pop_front();
                    chk("out_data_b", 32'(out_data_b), 32'(it.d));
                    chk("out_f_b", 32'(out_f_b), 32'(it.f));
                    logb_f.push_back(out_f_b);
                end
            end
            if (in_valid_b && in_ready_b) begin
                it.d   = in_data_b;
                it.f   = ($countones(in_data_b) > 8);
                it.cyc = cyc;
                if (it.f && mb_flips < 15) mb_flips++;
                sbb.push_back(it);
            end
        end
    end

    task automatic send(input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        input_activacion = d;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=no_ready required=ready");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        in_valid_b = 1'b1;
        in_data_b = d;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready_b) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_b_timeout actual=no_ready required=ready");
        end
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic drain_b();
        bit ok;
        ok = 1'b0;
        in_valid_b = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sbb.size() == 0 && !out_valid_b) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain_b_timeout actual=%0d required=0", sbb.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n0;
        logic [15:0] wa, wb, wc, wd;
        wa = 16'h1234; wb = 16'hFFFF; wc = 16'h0F0F; wd = 16'h8001;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_num_flips", 32'(num_flips), 32'd0);
        chk("rst_out_data", 32'(out_activacion), 32'd0);
        chk("rst_out_f", 32'(out_f_bit), 32'd0);
        @(posedge clk); #1;

        // Full inversion then an exact tie
        lat_chk = 1'b1;
        n0 = log_f.size();
        send(16'hFFFF);
        send(16'h00FF);
        drain();
        lat_chk = 1'b0;
        chk("t1_f0", 32'(log_f[n0]), 32'd1);
        chk("t1_f1", 32'(log_f[n0+1]), 32'd0);
        chk("t1_flips", 32'(num_flips), 32'd1);

        // History now 0x00FF: repeated 0xFF00 keeps inverting
        n0 = log_f.size();
        send(16'hFF00);
        send(16'hFF00);
        drain();
        chk("t2_f0", 32'(log_f[n0]), 32'd1);
        chk("t2_f1", 32'(log_f[n0+1]), 32'd1);
        chk("t2_flips", 32'(num_flips), 32'd3);

        // Backpressure for six cycles
        n0 = log_d.size();
        out_ready = 1'b0;
        fork
            begin
                send(wa); send(wb); send(wc); send(wd);
            end
            begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                    chk("stall_hold", 32'(out_activacion), 32'(wa));
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("t3_order0", 32'(log_d[n0]), 32'(wa));
        chk("t3_order1", 32'(log_d[n0+1]), 32'(wb));
        chk("t3_order2", 32'(log_d[n0+2]), 32'(wc));
        chk("t3_order3", 32'(log_d[n0+3]), 32'(wd));

        // Reset with both stages occupied
        out_ready = 1'b0;
        send(16'hAAAA);
        send(16'h5555);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n0 = log_f.size();
        send(16'hFFFF);
        drain();
        chk("t6_f", 32'(log_f[n0]), 32'd1);
        chk("t6_flips", 32'(num_flips), 32'd1);

        // Random traffic with random backpressure
        for (int k = 0; k < 600; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            input_activacion = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();
        chk("rand_flips", 32'(num_flips), 32'(m_flips));

        // Ones-count mode, history independent
        n0 = logb_f.size();
        send_b(16'h01FF);
        send_b(16'h00FF);
        drain_b();
        chk("t4_f0", 32'(logb_f[n0]), 32'd1);
        chk("t4_f1", 32'(logb_f[n0+1]), 32'd0);

        // Saturation of the 4-bit counter and clear
        for (int k = 0; k < 20; k++) send_b(16'hFFFF);
        drain_b();
        chk("t5_sat", 32'(num_flips_b), 32'd15);
        chk("t5_model", 32'(num_flips_b), 32'(mb_flips));
        clr_b = 1'b1;
        @(posedge clk); #1;
        clr_b = 1'b0;
        @(negedge clk);
        chk("t5_clr", 32'(num_flips_b), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("sbb_empty", 32'(sbb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
